// File: rtl/fifo_ff_pkg.sv
// Shared defaults and pointer helper for the flip-flop FIFO.
// Pointers wrap explicitly, so DEPTH does not have to be a power of two.
package fifo_ff_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ff_if.sv
// Producer/consumer bundle for fifo_ff.
// The FIFO sits on the slave modport; the user logic sits on the master modport.
interface fifo_ff_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    logic                       wr_en;
    logic [WIDTH-1:0]           wr_data;
    logic                       rd_en;
    logic [WIDTH-1:0]           rd_data;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH):0]     occup;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, empty, full, occup
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, empty, full, occup
    );
endinterface

// File: rtl/fifo_ff_ctrl.sv
// Pointer, occupancy and status control for fifo_ff.
// Status flags decode the registered count, so they never see wr_en/rd_en directly.
module fifo_ff_ctrl
    import fifo_ff_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic                        rd_en,
    output logic                        wr_acc,
    output logic [$clog2(DEPTH)-1:0]    wr_ptr,
    output logic [$clog2(DEPTH)-1:0]    rd_ptr,
    output logic [$clog2(DEPTH):0]      occup,
    output logic                        empty,
    output logic                        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;

    logic rd_acc;

    assign empty  = (occup == '0);
    assign full   = (occup == OW'(DEPTH));
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occup  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            // A concurrent accepted read and write cancel out.
            case ({wr_acc, rd_acc})
                2'b10:   occup <= occup + OW'(1);
                2'b01:   occup <= occup - OW'(1);
                default: occup <= occup;
            endcase
        end
    end

endmodule

// File: rtl/fifo_ff.sv
// Single-clock first-word-fall-through FIFO with register-array storage.
// The head word is always on rd_data; consumers qualify it with ~empty.
module fifo_ff
    import fifo_ff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_ff_if.slave    bus
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               wr_acc;

    fifo_ff_ctrl #(
        .DEPTH  (DEPTH)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (bus.wr_en),
        .rd_en  (bus.rd_en),
        .wr_acc (wr_acc),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .occup  (bus.occup),
        .empty  (bus.empty),
        .full   (bus.full)
    );

    // Storage is cleared on reset so rd_data never shows unknown values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.rd_data = mem[rd_ptr];

endmodule

// File: tb/tb_fifo_ff.sv
// Directed and random checks of fifo_ff against a queue scoreboard.
// Expected data is pushed on accepted writes and popped on accepted reads.
module tb_fifo_ff;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    fifo_ff_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_ff #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned        passed;
    int unsigned        total;
    logic [WIDTH-1:0]   sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".occup"}, 64'(bus.occup), 64'(sb.size()));
        check({tag, ".empty"}, 64'(bus.empty), 64'(sb.size() == 0));
        check({tag, ".full"},  64'(bus.full),  64'(sb.size() == DEPTH));
    endtask

    // One clock: drive, check popped head before the edge, update model, check status after.
    task automatic cycle(input logic wr, input logic [WIDTH-1:0] data, input logic rd, input string tag);
        logic wr_ok;
        logic rd_ok;
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.rd_en   = rd;
        wr_ok = wr && (sb.size() < DEPTH);
        rd_ok = rd && (sb.size() > 0);
        if (rd_ok) begin
            check({tag, ".rd_data"}, 64'(bus.rd_data), 64'(sb.pop_front()));
        end
        if (wr_ok) begin
            sb.push_back(data);
        end
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".occup"},   64'(bus.occup),   64'(0));
        check({tag, ".empty"},   64'(bus.empty),   64'(1));
        check({tag, ".full"},    64'(bus.full),    64'(0));
        check({tag, ".rd_data"}, 64'(bus.rd_data), 64'(0));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;

        // Reset held with random requests
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'($urandom_range(1));
            bus.rd_en   = 1'($urandom_range(1));
            bus.wr_data = $urandom;
            @(posedge clk);
            #1;
        end
        check_reset_state("reset");
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("post_reset");

        // Fill 0..15, then a dropped write
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, "fill");
        end
        check("fill.full_now", 64'(bus.full), 64'(1));
        cycle(1'b1, 32'hDEAD, 1'b0, "overflow");
        check("overflow.occup", 64'(bus.occup), 64'(DEPTH));

        // Drain 0..15, then a read on empty
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.head", 64'(bus.rd_data), 64'(i));
            cycle(1'b0, '0, 1'b1, "drain");
        end
        check("drain.empty_now", 64'(bus.empty), 64'(1));
        cycle(1'b0, '0, 1'b1, "underflow");
        check("underflow.occup", 64'(bus.occup), 64'(0));
        cycle(1'b1, 32'hA5A5_0001, 1'b0, "after_underflow");
        check("after_underflow.head", 64'(bus.rd_data), 64'(32'hA5A5_0001));
        cycle(1'b0, '0, 1'b1, "after_underflow_pop");

        // Steady occupancy of 5 with concurrent read/write across wraps
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h1000 + WIDTH'(i), 1'b0, "pre_sim");
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'h2000 + WIDTH'(i), 1'b1, "simul");
            check("simul.occup5", 64'(bus.occup), 64'(5));
        end
        while (sb.size() > 0) cycle(1'b0, '0, 1'b1, "simul_drain");

        // Full boundary: only the read is accepted
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'h3000 + WIDTH'(i), 1'b0, "bfill");
        end
        cycle(1'b1, 32'hBAD0, 1'b1, "full_rw");
        check("full_rw.occup15", 64'(bus.occup), 64'(DEPTH - 1));
        while (sb.size() > 0) cycle(1'b0, '0, 1'b1, "bdrain");

        // Empty boundary: only the write is accepted
        cycle(1'b1, 32'h4444, 1'b1, "empty_rw");
        check("empty_rw.occup1", 64'(bus.occup), 64'(1));
        check("empty_rw.head", 64'(bus.rd_data), 64'(32'h4444));

        // Random traffic with a reset pulse in the middle
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                bus.wr_en = 1'b1;
                bus.rd_en = 1'b1;
                rst_n = 1'b0;
                #1;
                check_reset_state("mid_reset");
                sb.delete();
                @(posedge clk);
                #1;
                check_reset_state("mid_reset_hold");
                rst_n = 1'b1;
            end
            cycle(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), "rand");
        end

        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
